setup_move_sequencer: RTL and testbench

SETUP_MOVE_SEQUENCER -- requirements
Module: setup_move_sequencer

---
 rtl/setup_move_sequencer.sv | 171 +++++++++++++++++
 tb/tb_setup_move_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/setup_move_sequencer.sv
// setup_move_sequencer: replays the cube setup moves for one scan step.
// A request latches the step index, walks that step's ROM row one move at a
// time over a valid/ready handshake to the motor driver, then waits for the
// colour sensors to settle before reporting color_sensor_stable.
// Optional build macro: SETUP_MOVE_SETTLE_TIMER_EN. When it is defined, the
// settle phase lasts SETTLE_CYCLES clocks. Otherwise it lasts a single clock.
module setup_move_sequencer #(
    parameter logic [19:0] SETTLE_CYCLES = 20'd1000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       send_setup_moves,
    input  logic [5:0] counter,
    output logic [2:0] move_face,
    output logic [1:0] move_turn,
    output logic       move_valid,
    input  logic       move_ready,
    output logic       color_sensor_stable,
    output logic       overrun
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_ISSUE  = 2'd2;
    localparam logic [1:0] ST_SETTLE = 2'd3;

    localparam logic [2:0] FACE_U = 3'd0;
    localparam logic [2:0] FACE_L = 3'd1;
    localparam logic [2:0] FACE_F = 3'd2;
    localparam logic [2:0] FACE_B = 3'd4;
    localparam logic [2:0] FACE_D = 3'd5;

    localparam logic [1:0] TURN_CW   = 2'd1;
    localparam logic [1:0] TURN_CCW  = 2'd2;
    localparam logic [1:0] TURN_HALF = 2'd3;

    // ROM word layout: {end, face[2:0], turn[1:0]}
    localparam logic [5:0] MOVE_END = 6'b100000;

    function automatic logic [5:0] mv(input logic [2:0] face, input logic [1:0] turn);
        return {1'b0, face, turn};
    endfunction

    // Scan batch plan: most steps give the top face a quarter turn, step 3
    // repositions the cube, every ninth step flips the top and bottom layers,
    // and steps 53-63 are spare (no moves).
    function automatic logic [5:0] rom_move(input logic [5:0] row, input logic [3:0] idx);
        logic [5:0] word_s;
        word_s = MOVE_END;
        case (row)
            6'd3: begin
                case (idx)
                    4'd0:    word_s = mv(FACE_U, TURN_CW);
                    4'd1:    word_s = mv(FACE_F, TURN_CW);
                    4'd2:    word_s = mv(FACE_B, TURN_CCW);
                    4'd3:    word_s = mv(FACE_L, TURN_CW);
                    4'd4:    word_s = mv(FACE_U, TURN_CW);
                    4'd5:    word_s = mv(FACE_F, TURN_CW);
                    4'd6:    word_s = mv(FACE_B, TURN_CCW);
                    default: word_s = MOVE_END;
                endcase
            end
            6'd9, 6'd18, 6'd27, 6'd36, 6'd45: begin
                case (idx)
                    4'd0:    word_s = mv(FACE_U, TURN_HALF);
                    4'd1:    word_s = mv(FACE_D, TURN_HALF);
                    default: word_s = MOVE_END;
                endcase
            end
            default: begin
                if ((row <= 6'd52) && (idx == 4'd0)) begin
                    word_s = mv(FACE_U, TURN_CW);
                end else begin
                    word_s = MOVE_END;
                end
            end
        endcase
        return word_s;
    endfunction

    logic [1:0] state_r;
    logic [5:0] row_r;
    logic [4:0] index_r;
    logic [5:0] rom_word_s;
    logic       fetch_end_s;

`ifdef SETUP_MOVE_SETTLE_TIMER_EN
    logic [19:0] settle_cnt_r;
`else
    // SETTLE_CYCLES has no effect when the settle timer is not built.
    if (SETTLE_CYCLES == 20'd0) begin : g_settle_cycles_unused
    end
`endif

    // ROM lookup for the current move; index 16 counts as END.
    always_comb begin
        rom_word_s  = rom_move(row_r, index_r[3:0]);
        fetch_end_s = index_r[4] | rom_word_s[5];
    end

    // Sequencer FSM, move outputs, sensor-stable flag and sticky overrun.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r             <= ST_IDLE;
            row_r               <= 6'd0;
            index_r             <= 5'd0;
            move_valid          <= 1'b0;
            move_face           <= 3'd0;
            move_turn           <= 2'd0;
            overrun             <= 1'b0;
            color_sensor_stable <= 1'b1;
`ifdef SETUP_MOVE_SETTLE_TIMER_EN
            settle_cnt_r        <= 20'd0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (send_setup_moves) begin
                        row_r               <= counter;
                        index_r             <= 5'd0;
                        color_sensor_stable <= 1'b0;
                        state_r             <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (fetch_end_s) begin
                        state_r      <= ST_SETTLE;
`ifdef SETUP_MOVE_SETTLE_TIMER_EN
                        settle_cnt_r <= SETTLE_CYCLES - 20'd1;
`endif
                    end else begin
                        move_face  <= rom_word_s[4:2];
                        move_turn  <= rom_word_s[1:0];
                        move_valid <= 1'b1;
                        state_r    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (move_ready) begin
                        move_valid <= 1'b0;
                        index_r    <= index_r + 5'd1;
                        state_r    <= ST_FETCH;
                    end
                end
                ST_SETTLE: begin
`ifdef SETUP_MOVE_SETTLE_TIMER_EN
                    if (settle_cnt_r == 20'd0) begin
                        color_sensor_stable <= 1'b1;
                        state_r             <= ST_IDLE;
                    end else begin
                        settle_cnt_r <= settle_cnt_r - 20'd1;
                    end
`else
                    color_sensor_stable <= 1'b1;
                    state_r             <= ST_IDLE;
`endif
                end
                default: begin
                    move_valid <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase

            // A request arriving while a sequence runs is dropped and remembered.
            if (send_setup_moves && (state_r != ST_IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_setup_move_sequencer.sv
// Scoreboard bench for setup_move_sequencer: the stimulus pushes each step's
// expected move list, a monitor compares accepted moves, handshake timing,
// settle length, overrun and reset behaviour against a transaction model.
module tb_setup_move_sequencer;

    localparam logic [19:0] SETTLE = 20'd4;
`ifdef SETUP_MOVE_SETTLE_TIMER_EN
    localparam int SETTLE_LEN = 4;
`else
    localparam int SETTLE_LEN = 1;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       send_setup_moves = 1'b0;
    logic [5:0] counter = 6'd0;
    logic       move_ready = 1'b0;
    logic [2:0] move_face;
    logic [1:0] move_turn;
    logic       move_valid;
    logic       color_sensor_stable;
    logic       overrun;

    int total = 0;
    int bad   = 0;
    int ready_mode = 0;   // 0: always ready, 1: stall 3 cycles, 2: random

    logic [4:0] exp_q[$];  // expected {face, turn} of each move
    int         req_q[$];  // expected move count of each request

    setup_move_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
        .clock(clock),
        .reset(reset),
        .send_setup_moves(send_setup_moves),
        .counter(counter),
        .move_face(move_face),
        .move_turn(move_turn),
        .move_valid(move_valid),
        .move_ready(move_ready),
        .color_sensor_stable(color_sensor_stable),
        .overrun(overrun)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference plan for the rows the bench exercises.
    task automatic push_row(input int row);
        logic [4:0] plan3 [7];
        plan3 = '{5'b00001, 5'b01001, 5'b10010, 5'b00101, 5'b00001, 5'b01001, 5'b10010};
        if (row == 0) begin
            exp_q.push_back(5'b00001);
            req_q.push_back(1);
        end else if (row == 3) begin
            foreach (plan3[i]) exp_q.push_back(plan3[i]);
            req_q.push_back(7);
        end else begin
            req_q.push_back(0);
        end
    endtask

    task automatic send_row(input int row);
        @(negedge clock);
        push_row(row);
        counter = 6'(row);
        send_setup_moves = 1'b1;
        @(negedge clock);
        send_setup_moves = 1'b0;
    endtask

    task automatic send_ignored(input int row);
        counter = 6'(row);
        send_setup_moves = 1'b1;
        @(negedge clock);
        send_setup_moves = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (!color_sensor_stable && k < 400) begin
            @(negedge clock);
            k++;
        end
        if (!color_sensor_stable) check("wait_idle_timeout", 0, 1);
    endtask

    task automatic wait_valid();
        int k;
        k = 0;
        while (!move_valid && k < 100) begin
            @(negedge clock);
            k++;
        end
        if (!move_valid) check("wait_valid_timeout", 0, 1);
    endtask

    // Motor driver model: move_ready behaviour selected by ready_mode.
    initial begin : ready_driver
        int stall;
        stall = 0;
        forever begin
            @(negedge clock);
            if (!move_valid) begin
                stall = 0;
                move_ready = (ready_mode == 0);
            end else begin
                move_ready = (ready_mode == 0) || (ready_mode == 1 && stall >= 3) ||
                             (ready_mode == 2 && $urandom_range(0, 1) == 1);
                stall++;
            end
        end
    end

    // Monitor: transaction model of the handshake, settle and overrun rules.
    initial begin : monitor
        int n, phase, phase0, left, settle_at;
        bit wait_present, m_ovr;
        logic prev_valid;
        logic [2:0] prev_face;
        logic [1:0] prev_turn;
        logic [4:0] e;
        n = 0; phase = 0; left = 0; settle_at = 0;
        wait_present = 1'b0; m_ovr = 1'b0;
        prev_valid = 1'b0; prev_face = 3'd0; prev_turn = 2'd0;
        forever begin
            @(posedge clock);
            #1;
            n++;
            phase0 = phase;
            if (reset) begin
                check("rst_valid", int'(move_valid), 0);
                check("rst_face", int'(move_face), 0);
                check("rst_turn", int'(move_turn), 0);
                check("rst_overrun", int'(overrun), 0);
                check("rst_stable", int'(color_sensor_stable), 1);
                phase = 0; left = 0; wait_present = 1'b0; m_ovr = 1'b0;
                exp_q.delete();
                req_q.delete();
            end else begin
                if (send_setup_moves && phase0 != 0) m_ovr = 1'b1;
                if (wait_present) begin
                    check("valid_latency", int'(move_valid), 1);
                    wait_present = 1'b0;
                end
                if (prev_valid && !move_ready) begin
                    check("hold_valid", int'(move_valid), 1);
                    check("hold_move", int'({move_face, move_turn}), int'({prev_face, prev_turn}));
                end
                if (prev_valid && move_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_move", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("move", int'({prev_face, prev_turn}), int'(e));
                    end
                    check("accept_drop", int'(move_valid), 0);
                    left--;
                    if (left > 0) begin
                        wait_present = 1'b1;
                    end else begin
                        phase = 2;
                        settle_at = n + 1 + SETTLE_LEN;
                    end
                end
                if (phase0 == 0) begin
                    if (send_setup_moves) begin
                        check("req_stable_low", int'(color_sensor_stable), 0);
                        if (req_q.size() == 0) check("unexpected_req", 1, 0);
                        else left = req_q.pop_front();
                        if (left > 0) begin
                            phase = 1;
                            wait_present = 1'b1;
                        end else begin
                            phase = 2;
                            settle_at = n + 1 + SETTLE_LEN;
                        end
                    end else begin
                        check("idle_stable", int'(color_sensor_stable), 1);
                    end
                end else if (phase0 == 2) begin
                    if (n == settle_at) begin
                        check("settle_done", int'(color_sensor_stable), 1);
                        phase = 0;
                    end else begin
                        check("settle_low", int'(color_sensor_stable), 0);
                    end
                end
                if (phase0 != 1) check("valid_outside_issue", int'(move_valid), 0);
                check("overrun", int'(overrun), int'(m_ovr));
            end
            prev_valid = move_valid;
            prev_face  = move_face;
            prev_turn  = move_turn;
        end
    end

    // Stimulus: directed scenarios followed by randomized requests.
    initial begin : stim
        int r;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        ready_mode = 0; send_row(0);  wait_idle();
        ready_mode = 1; send_row(3);  wait_idle();
        ready_mode = 0; send_row(60); wait_idle();

        ready_mode = 1; send_row(3); wait_valid(); send_ignored(0); wait_idle();

        ready_mode = 1; send_row(3); wait_valid();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        reset = 1'b1;
        push_row(0);
        counter = 6'd0;
        send_setup_moves = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        send_setup_moves = 1'b0;
        repeat (2) @(negedge clock);

        for (int t = 0; t < 40; t++) begin
            ready_mode = $urandom_range(0, 2);
            case ($urandom_range(0, 3))
                0:       r = 0;
                1:       r = 3;
                default: r = $urandom_range(53, 63);
            endcase
            send_row(r);
            if ((r == 0 || r == 3) && $urandom_range(0, 3) == 0) begin
                wait_valid();
                send_ignored($urandom_range(0, 63));
            end
            wait_idle();
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end

        repeat (3) @(negedge clock);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
